// File: rtl/bpm_pkg.sv
// Shared types and constant helpers for the BPM tempo controller.
package bpm_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, ACCUM, DIVIDE, PUBLISH} state_t;

  localparam int FRAC_BITS = 8;

  function automatic int min_iv(input int sample_freq, input int max_bpm);
    return (60 * sample_freq) / max_bpm;
  endfunction

  function automatic int max_iv(input int sample_freq, input int min_bpm);
    return (60 * sample_freq) / min_bpm;
  endfunction

  function automatic logic [31:0] bpm_dividend(input int sample_freq);
    return 32'(60 * sample_freq) << FRAC_BITS;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, 32-bit dividend.
module seq_divider #(
  parameter int DIVISOR_W = 17
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [31:0]          dividend,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          quotient,
  output logic [DIVISOR_W-1:0] remainder
);

  logic [DIVISOR_W-1:0] dvsr;
  logic [5:0]           iter;
  logic [DIVISOR_W:0]   trial;

  assign trial = {remainder, quotient[31]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
      iter      <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quotient  <= dividend;
        remainder <= '0;
        dvsr      <= divisor;
        iter      <= 6'd32;
        busy      <= 1'b1;
      end else if (busy) begin
        if (trial >= {1'b0, dvsr}) begin
          remainder <= DIVISOR_W'(trial - {1'b0, dvsr});
          quotient  <= {quotient[30:0], 1'b1};
        end else begin
          remainder <= trial[DIVISOR_W-1:0];
          quotient  <= {quotient[30:0], 1'b0};
        end
        // down-counter; terminal count ends the divide
        iter <= iter - 6'd1;
        if (iter == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bpm_tempo_controller.sv
// Range-gates beat intervals, keeps a rolling history and publishes a smoothed Q8.8 BPM.
//  state   | meaning
//  IDLE    | ready for an interval
//  CHECK   | range-gate the registered interval, track rejects
//  ACCUM   | write history slot, update running sum and fill
//  DIVIDE  | run the shared divider on the mean interval
//  PUBLISH | one cycle with bpm_valid high
module bpm_tempo_controller
  import bpm_pkg::*;
#(
  parameter int SAMPLE_FREQ       = 8000,
  parameter int INTERVAL_W        = 17,
  parameter int HIST_DEPTH        = 4,
  parameter int MIN_BPM           = 40,
  parameter int MAX_BPM           = 200,
  parameter int MAX_CONSEC_REJECT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  interval_valid,
  output logic                  interval_ready,
  input  logic [INTERVAL_W-1:0] interval_in,
  output logic                  bpm_valid,
  output logic [15:0]           bpm_q8_8,
  output logic                  bpm_locked,
  output logic                  reject_pulse,
  output logic [7:0]            reject_count
);

  localparam int PW    = $clog2(HIST_DEPTH);
  localparam int SUM_W = INTERVAL_W + PW;
  localparam int FW    = PW + 1;
  localparam int CW    = $clog2(MAX_CONSEC_REJECT + 1);
  localparam logic [INTERVAL_W-1:0] MIN_IV = INTERVAL_W'(min_iv(SAMPLE_FREQ, MAX_BPM));
  localparam logic [INTERVAL_W-1:0] MAX_IV = INTERVAL_W'(max_iv(SAMPLE_FREQ, MIN_BPM));
  localparam logic [31:0]           DIVIDEND = bpm_dividend(SAMPLE_FREQ);

  state_t                state, state_nxt;
  logic [INTERVAL_W-1:0] iv_q;
  logic [INTERVAL_W-1:0] hist [HIST_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [FW-1:0]         fill, fill_nxt;
  logic [SUM_W-1:0]      sum, sum_nxt;
  logic [CW-1:0]         consec, consec_nxt;
  logic                  in_range, hist_full, full_after;
  logic [INTERVAL_W-1:0] evicted, divisor;
  logic                  div_start, div_busy, div_done;
  logic [31:0]           div_quo;
  logic [INTERVAL_W-1:0] div_rem_unused;

  assign in_range       = (iv_q >= MIN_IV) && (iv_q <= MAX_IV);
  assign hist_full      = (fill == FW'(HIST_DEPTH));
  assign evicted        = hist_full ? hist[wr_ptr] : '0;
  assign sum_nxt        = sum + SUM_W'(iv_q) - SUM_W'(evicted);
  assign fill_nxt       = hist_full ? fill : fill + FW'(1);
  assign full_after     = (fill_nxt == FW'(HIST_DEPTH));
  assign consec_nxt     = consec + CW'(1);
  assign divisor        = sum[SUM_W-1:PW];
  assign div_start      = (state == DIVIDE) && !div_busy && !div_done;
  assign interval_ready = (state == IDLE);

  seq_divider #(.DIVISOR_W(INTERVAL_W)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem_unused)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (interval_valid && interval_ready) state_nxt = CHECK;
      CHECK:   state_nxt = in_range ? ACCUM : IDLE;
      ACCUM:   state_nxt = full_after ? DIVIDE : IDLE;
      DIVIDE:  if (div_done) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iv_q         <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      sum          <= '0;
      consec       <= '0;
      bpm_valid    <= 1'b0;
      bpm_q8_8     <= '0;
      bpm_locked   <= 1'b0;
      reject_pulse <= 1'b0;
      reject_count <= '0;
    end else begin
      bpm_valid    <= 1'b0;
      reject_pulse <= 1'b0;
      case (state)
        IDLE: if (interval_valid && interval_ready) iv_q <= interval_in;
        CHECK: begin
          if (in_range) begin
            consec <= '0;
          end else begin
            reject_pulse <= 1'b1;
            if (reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
            if (consec_nxt == CW'(MAX_CONSEC_REJECT)) begin
              for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
              wr_ptr     <= '0;
              fill       <= '0;
              sum        <= '0;
              consec     <= '0;
              bpm_locked <= 1'b0;
            end else begin
              consec <= consec_nxt;
            end
          end
        end
        ACCUM: begin
          hist[wr_ptr] <= iv_q;
          wr_ptr       <= wr_ptr + PW'(1);
          sum          <= sum_nxt;
          fill         <= fill_nxt;
        end
        // result registered on entry to PUBLISH so the pulse lines up with that state
        DIVIDE: if (div_done) begin
          bpm_q8_8   <= (div_quo[31:16] != 16'd0) ? 16'hFFFF : div_quo[15:0];
          bpm_valid  <= 1'b1;
          bpm_locked <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
